// File: rtl/multibyte_add_seq.sv
// Byte-serial N-byte adder sequencer: feeds an external 8-bit adder LSB first,
// chains its carry, and publishes the full-width sum once the top byte is done.
//
// state | meaning
// IDLE  | waiting for iStart; adder feed forced to 0
// RUN   | one byte per cycle through the adder, idx selects the byte
// DONE  | single-cycle result pulse, then back to IDLE
module multibyte_add_seq #(
  parameter int NBYTES = 4
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iStart,
  input  logic [8*NBYTES-1:0]   iData_a,
  input  logic [8*NBYTES-1:0]   iData_b,
  input  logic                  iC,
  output logic                  oBusy,
  output logic                  oDone,
  output logic [8*NBYTES-1:0]   oData,
  output logic                  oData_C,
  output logic [7:0]            oAdd_a,
  output logic [7:0]            oAdd_b,
  output logic                  oAdd_c,
  input  logic [7:0]            iAdd_sum,
  input  logic                  iAdd_c
);

  localparam int W    = 8 * NBYTES;
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [W-1:0]    data_q, data_d;
  logic            data_c_q, data_c_d;
  logic            done_q, done_d;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      acc_q    <= '0;
      data_q   <= '0;
      data_c_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      acc_q    <= acc_d;
      data_q   <= data_d;
      data_c_q <= data_c_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    acc_d    = acc_q;
    data_d   = data_q;
    data_c_d = data_c_q;
    done_d   = 1'b0;
    oAdd_a   = 8'h00;
    oAdd_b   = 8'h00;
    oAdd_c   = 1'b0;

    case (state_q)
      IDLE: begin
        if (iStart) begin
          a_d     = iData_a;
          b_d     = iData_b;
          carry_d = iC;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        oAdd_a = a_q[idx_q*8 +: 8];
        oAdd_b = b_q[idx_q*8 +: 8];
        oAdd_c = carry_q;
        acc_d[idx_q*8 +: 8] = iAdd_sum;
        carry_d = iAdd_c;
        if (idx_q == LAST_IDX) begin
          // acc_d already holds the top byte, so the published sum is never partial
          data_d   = acc_d;
          data_c_d = iAdd_c;
          done_d   = 1'b1;
          state_d  = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign oBusy   = (state_q == RUN) || (state_q == DONE);
  assign oDone   = done_q;
  assign oData   = data_q;
  assign oData_C = data_c_q;

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Scoreboard bench for multibyte_add_seq (NBYTES=4) driving a behavioural 8-bit adder.
module tb_multibyte_add_seq;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] da, db;
  logic         cin;
  logic         busy, done;
  logic [W-1:0] dout;
  logic         dout_c;
  logic [7:0]   add_a, add_b, add_sum;
  logic         add_cin, add_cout;

  typedef struct {
    logic [W-1:0] data;
    logic         c;
  } exp_t;
  exp_t exp_q[$];

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  // stand-in for the team's 8-bit adder stage
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_cin};

  multibyte_add_seq #(.NBYTES(NB)) dut (
    .iClk(clk), .iRst(rst), .iStart(start),
    .iData_a(da), .iData_b(db), .iC(cin),
    .oBusy(busy), .oDone(done), .oData(dout), .oData_C(dout_c),
    .oAdd_a(add_a), .oAdd_b(add_b), .oAdd_c(add_cin),
    .iAdd_sum(add_sum), .iAdd_c(add_cout)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result_data", {32'd0, dout}, {32'd0, e.data});
        chk("result_carry", {63'd0, dout_c}, {63'd0, e.c});
      end
    end
  end

  // issue one request, wait for oDone, check latency from the accept edge
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic [W-1:0] ed, input logic ec);
    int n;
    exp_t e;
    @(negedge clk);
    start = 1'b1; da = a; db = b; cin = c;
    e.data = ed; e.c = ec;
    exp_q.push_back(e);
    @(posedge clk);
    #1 start = 1'b0; da = '0; db = '0; cin = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk);
      n++;
      #1;
    end
    chk("done_latency", 64'(n), 64'(NB));
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_done"}, {63'd0, done}, 64'd0);
    chk({tag, "_data"}, {32'd0, dout}, 64'd0);
    chk({tag, "_carry"}, {63'd0, dout_c}, 64'd0);
    chk({tag, "_addfeed"}, {47'd0, add_a, add_b, add_cin}, 64'd0);
  endtask

  initial begin
    int bcnt;
    rst = 1'b1; start = 1'b0; da = '0; db = '0; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_zero_outputs("reset");
    @(negedge clk) rst = 1'b0;

    run_op(32'h00000002, 32'h00000001, 1'b0, 32'h00000003, 1'b0);
    run_op(32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0);
    run_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1);

    // first RUN cycle must present byte 0 and carry-in to the adder
    @(negedge clk);
    start = 1'b1; da = 32'h80000082; db = 32'h80000080; cin = 1'b1;
    begin exp_t e; e.data = 32'h00000103; e.c = 1'b1; exp_q.push_back(e); end
    @(posedge clk);
    #1 start = 1'b0;
    chk("run0_feed", {47'd0, add_a, add_b, add_cin}, {47'd0, 8'h82, 8'h80, 1'b1});
    repeat (NB) @(posedge clk);
    repeat (5) @(posedge clk);
    #1 chk("hold_data", {32'd0, dout}, 64'h103);
    chk("hold_carry", {63'd0, dout_c}, 64'd1);
    chk("idle_feed", {47'd0, add_a, add_b, add_cin}, 64'd0);

    // start pulses while busy are ignored; busy lasts NBYTES+1 cycles
    @(negedge clk);
    start = 1'b1; da = 32'h12345678; db = 32'h11111111; cin = 1'b0;
    begin exp_t e; e.data = 32'h23456789; e.c = 1'b0; exp_q.push_back(e); end
    bcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy) bcnt++;
      start = busy && (i == 0 || i == 2 || i == 4);
      da = 32'hFFFFFFFF; db = 32'h00000001; cin = 1'b1;
    end
    start = 1'b0;
    chk("busy_cycles", 64'(bcnt), 64'd5);
    repeat (4) @(posedge clk);

    // reset in the 2nd RUN cycle aborts with no done pulse
    @(negedge clk);
    start = 1'b1; da = 32'h01010101; db = 32'h02020202; cin = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_zero_outputs("abort");
    @(negedge clk) rst = 1'b0;
    run_op(32'hDEADBEEF, 32'h01020304, 1'b1, 32'hDFAFC1F4, 1'b0);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
